// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ bursting requesters.
// Each grant forwards up to MAX_BURST words, tagged {source id, payload}, under fifo_full backpressure.
module fifo_wr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          wr_clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [ID_W+DATA_WIDTH-1:0]    fifo_wdata,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [ID_W:0]   NUM_REQ_W  = (ID_W+1)'(NUM_REQ);
  localparam logic [7:0]      BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [ID_W-1:0] LAST_INIT  = ID_W'(NUM_REQ - 1);

  state_t                state_reg, state_next;
  logic [ID_W-1:0]       grant_id_reg, grant_id_next;
  logic [ID_W-1:0]       last_grant_reg, last_grant_next;
  logic [7:0]            burst_cnt_reg, burst_cnt_next;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic                  pick_found;
  logic [ID_W-1:0]       pick_id;
  logic [ID_W:0]         cand;
  logic                  xfer;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts just after the last winner; one conditional subtract keeps
  // the wrap correct for non power-of-two NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant_reg} + (ID_W+1)'(k);
      if (cand >= NUM_REQ_W) begin
        cand = cand - NUM_REQ_W;
      end
      if (!pick_found && req_valid[cand[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_id_next   = grant_id_reg;
    last_grant_next = last_grant_reg;
    burst_cnt_next  = burst_cnt_reg;
    req_ready       = '0;
    xfer            = 1'b0;
    fifo_wr_en      = 1'b0;
    fifo_wdata      = '0;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_id_next  = pick_id;
          burst_cnt_next = '0;
          state_next     = GRANT;
        end
      end
      GRANT: begin
        req_ready[grant_id_reg] = !fifo_full;
        xfer       = req_valid[grant_id_reg] & !fifo_full;
        fifo_wr_en = xfer;
        if (xfer) begin
          fifo_wdata = {grant_id_reg, data_arr[grant_id_reg]};
        end
        // A full stall keeps the grant; withdrawal, last or burst limit ends it.
        if (!req_valid[grant_id_reg] ||
            (xfer && (req_last[grant_id_reg] || burst_cnt_reg == BURST_LAST))) begin
          state_next      = IDLE;
          last_grant_next = grant_id_reg;
        end else if (xfer) begin
          burst_cnt_next = burst_cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      grant_id_reg   <= '0;
      last_grant_reg <= LAST_INIT;
      burst_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      grant_id_reg   <= grant_id_next;
      last_grant_reg <= last_grant_next;
      burst_cnt_reg  <= burst_cnt_next;
    end
  end

  assign grant_id = grant_id_reg;
  assign busy     = (state_reg == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queued requester models, a write scoreboard checked by a
// negedge monitor (global order + inter-write gap, and per-source order), directed and random phases.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic            wr_clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_last;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW+1:0]   fifo_wdata;
  logic [1:0]      grant_id;
  logic            busy;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .wr_clk     (wr_clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wdata (fifo_wdata),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
  } word_t;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    int         gap;
  } exp_t;

  word_t      src_q   [NR][$];
  logic [7:0] src_exp [NR][$];
  exp_t       exp_q   [$];

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_wr_cyc = 0;
  bit         mark_req = 0;
  bit         started = 0;
  bit         dir_mode = 1;
  logic [NR-1:0] acc_mask = '0;

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required reaching the summary");
    $fatal(1, "watchdog expired");
  end

  // Requester models: drop the accepted head, present the next word just after each edge.
  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(posedge wr_clk);
      cyc++;
      #1;
      for (int i = 0; i < NR; i++) begin
        if (acc_mask[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
      acc_mask = '0;
      if (mark_req) begin
        last_wr_cyc = cyc;
        mark_req = 0;
      end
      for (int i = 0; i < NR; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i]         = 1'b1;
          req_data[i*DW +: DW] = src_q[i][0].data;
          req_last[i]          = src_q[i][0].last;
        end else begin
          req_valid[i]         = 1'b0;
          req_data[i*DW +: DW] = '0;
          req_last[i]          = 1'b0;
        end
      end
    end
  end

  // Monitor: handshake rules every cycle, scoreboard pop on every FIFO write.
  initial begin : monitor
    logic [NR-1:0] exp_ready;
    logic [7:0]    dat;
    logic [7:0]    want;
    int            id;
    exp_t          e;
    forever begin
      @(negedge wr_clk);
      acc_mask = req_valid & req_ready;
      if (started && rst_n) begin
        exp_ready = (busy && !fifo_full) ? (4'b0001 << grant_id) : 4'b0000;
        checks++;
        if (req_ready !== exp_ready || fifo_wr_en !== |(req_valid & exp_ready) ||
            (fifo_wr_en !== 1'b1 && fifo_wdata !== '0)) begin
          errors++;
          $display("FAIL handshake cyc=%0d: ready=%b wr_en=%b wdata=%h, required ready=%b wr_en=%b (wdata 0 when idle)",
                   cyc, req_ready, fifo_wr_en, fifo_wdata, exp_ready, |(req_valid & exp_ready));
        end
        if (fifo_wr_en === 1'b1) begin
          id  = int'(fifo_wdata[9:8]);
          dat = fifo_wdata[7:0];
          checks++;
          if (fifo_full !== 1'b0) begin
            errors++;
            $display("FAIL write_while_full cyc=%0d: fifo_full=%b, required 0", cyc, fifo_full);
          end
          checks++;
          if (src_exp[id].size() == 0) begin
            errors++;
            $display("FAIL source_order cyc=%0d: extra word %h from src %0d, required none", cyc, dat, id);
          end else begin
            want = src_exp[id].pop_front();
            if (dat !== want) begin
              errors++;
              $display("FAIL source_order cyc=%0d src=%0d: data %h, required %h", cyc, id, dat, want);
            end
          end
          if (dir_mode) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_write cyc=%0d: src=%0d data=%h, required no write", cyc, id, dat);
            end else begin
              e = exp_q.pop_front();
              if (id != int'(e.id) || dat !== e.data || (e.gap != 0 && cyc - last_wr_cyc != e.gap)) begin
                errors++;
                $display("FAIL directed_write cyc=%0d: src=%0d data=%h gap=%0d, required src=%0d data=%h gap=%0d",
                         cyc, id, dat, cyc - last_wr_cyc, e.id, e.data, e.gap);
              end
            end
            $display("write cyc=%0d src=%0d data=%h gap=%0d", cyc, id, dat, cyc - last_wr_cyc);
          end
          last_wr_cyc = cyc;
        end
      end
    end
  end

  task automatic push(input int s, input logic [7:0] d, input logic l, input int gap,
                      input bit to_sb, input bit to_glob);
    word_t w;
    exp_t  e;
    w.data = d;
    w.last = l;
    src_q[s].push_back(w);
    if (to_sb) src_exp[s].push_back(d);
    if (to_glob) begin
      e.id   = 2'(s);
      e.data = d;
      e.gap  = gap;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (fifo_wr_en !== 1'b0 || fifo_wdata !== '0 || req_ready !== '0 || grant_id !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: wr_en=%b wdata=%h ready=%b grant_id=%0d busy=%b, required all 0",
               name, fifo_wr_en, fifo_wdata, req_ready, grant_id, busy);
    end
  endtask

  task automatic assert_reset_now(input string name);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(name);
    for (int i = 0; i < NR; i++) begin
      src_q[i].delete();
      src_exp[i].delete();
    end
    exp_q.delete();
    acc_mask  = '0;
    fifo_full = 1'b0;
    repeat (2) @(negedge wr_clk);
    rst_n = 1'b1;
  endtask

  task automatic do_reset(input string name);
    @(posedge wr_clk);
    #2;
    assert_reset_now(name);
  endtask

  task automatic wait_until_size(input int n, input int max_cyc, input string name);
    int k = 0;
    while (exp_q.size() > n && k < max_cyc) begin
      @(negedge wr_clk);
      #1;
      k++;
    end
    checks++;
    if (exp_q.size() > n) begin
      errors++;
      $display("FAIL %s: timeout with %0d writes outstanding, required %0d", name, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic start_test();
    @(posedge wr_clk);
    #2;
  endtask

  initial begin
    int seq [NR];
    int k;
    bit pending;
    rst_n     = 1'b1;
    fifo_full = 1'b0;

    // Reset state, then one 3-word burst from requester 0.
    do_reset("reset_state");
    started = 1;
    start_test();
    push(0, 8'hA1, 1'b0, 1, 1, 1);
    push(0, 8'hA2, 1'b0, 1, 1, 1);
    push(0, 8'hA3, 1'b1, 1, 1, 1);
    mark_req = 1;
    wait_until_size(0, 20, "t1_drain");
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL t1_busy_on_last: busy=%b, required 1", busy);
    end
    @(negedge wr_clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL t1_busy_drop: busy=%b, required 0", busy);
    end

    // All four requesters streaming without last: bursts of 4, order 0,1,2,3,0.
    do_reset("t2_reset");
    start_test();
    for (int s = 0; s < NR; s++) begin
      for (int w = 0; w < 4; w++) push(s, 8'(s*16 + w), 1'b0, (w == 0) ? ((s == 0) ? 1 : 2) : 1, 1, 1);
    end
    for (int w = 4; w < 8; w++) push(0, 8'(w), 1'b0, (w == 4) ? 2 : 1, 1, 1);
    mark_req = 1;
    wait_until_size(0, 60, "t2_drain");

    // Requester 2 stalled by fifo_full for 5 cycles after its 2nd word.
    do_reset("t3_reset");
    start_test();
    push(2, 8'h20, 1'b0, 1, 1, 1);
    push(2, 8'h21, 1'b0, 1, 1, 1);
    push(2, 8'h22, 1'b0, 6, 1, 1);
    push(2, 8'h23, 1'b0, 1, 1, 1);
    push(2, 8'h24, 1'b0, 2, 1, 1);
    mark_req = 1;
    wait_until_size(3, 20, "t3_pre_stall");
    @(posedge wr_clk);
    #2;
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge wr_clk);
      #1;
      checks++;
      if (req_ready !== 4'b0000 || fifo_wr_en !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd2) begin
        errors++;
        $display("FAIL t3_stall c=%0d: ready=%b wr_en=%b busy=%b grant_id=%0d, required 0000 0 1 2",
                 c, req_ready, fifo_wr_en, busy, grant_id);
      end
    end
    @(posedge wr_clk);
    #2;
    fifo_full = 1'b0;
    wait_until_size(0, 20, "t3_drain");

    // Requester 1 withdraws after 2 words; 0 and 3 waiting -> 3 wins, then 0.
    do_reset("t4_reset");
    start_test();
    push(1, 8'h10, 1'b0, 1, 1, 1);
    push(1, 8'h11, 1'b0, 1, 1, 1);
    mark_req = 1;
    wait_until_size(1, 20, "t4_first");
    @(posedge wr_clk);
    #2;
    push(3, 8'h30, 1'b1, 3, 1, 1);
    push(0, 8'h40, 1'b1, 2, 1, 1);
    wait_until_size(0, 20, "t4_drain");

    // Asynchronous reset mid-burst, then requester 0 must win over 3.
    do_reset("t5_reset");
    start_test();
    push(2, 8'h50, 1'b0, 1, 1, 1);
    push(2, 8'h51, 1'b0, 1, 1, 1);
    push(2, 8'h52, 1'b0, 0, 0, 0);
    push(2, 8'h53, 1'b0, 0, 0, 0);
    mark_req = 1;
    wait_until_size(0, 20, "t5_partial");
    checks++;
    if (busy !== 1'b1 || fifo_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL t5_mid_burst: busy=%b wr_en=%b, required 1 1", busy, fifo_wr_en);
    end
    assert_reset_now("t5_async_reset");
    start_test();
    push(3, 8'h63, 1'b1, 2, 1, 1);
    push(0, 8'h60, 1'b1, 1, 1, 1);
    // global queue must list requester 0 first
    exp_q.delete();
    begin
      exp_t e0, e3;
      e0.id = 2'd0; e0.data = 8'h60; e0.gap = 1;
      e3.id = 2'd3; e3.data = 8'h63; e3.gap = 2;
      exp_q.push_back(e0);
      exp_q.push_back(e3);
    end
    mark_req = 1;
    wait_until_size(0, 20, "t5_after_reset");

    // Random valid/last/full traffic: per-source order, no loss, no duplication.
    do_reset("t6_reset");
    dir_mode = 0;
    for (int s = 0; s < NR; s++) seq[s] = 0;
    for (int c = 0; c < 10000; c++) begin
      @(posedge wr_clk);
      #2;
      fifo_full = ($urandom_range(0, 3) == 0);
      for (int s = 0; s < NR; s++) begin
        if (src_q[s].size() < 6 && $urandom_range(0, 2) == 0) begin
          push(s, 8'(seq[s]), ($urandom_range(0, 3) == 0), 0, 1, 0);
          seq[s]++;
        end
      end
    end
    @(posedge wr_clk);
    #2;
    fifo_full = 1'b0;
    k = 0;
    pending = 1;
    while (pending && k < 2000) begin
      @(negedge wr_clk);
      #1;
      k++;
      pending = 0;
      for (int s = 0; s < NR; s++) if (src_q[s].size() > 0) pending = 1;
    end
    for (int s = 0; s < NR; s++) begin
      checks++;
      if (src_exp[s].size() != 0) begin
        errors++;
        $display("FAIL t6_loss src=%0d: %0d words never written, required 0", s, src_exp[s].size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
